seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values 8 to 32.
REQ-002 Parameter MUL_EN, default 1; when 0, MUL returns 0 with flag ERR.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  reset; asynchronous, active-low.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 ALUK  input  3  operation select; encoding in package alu_pkg.
REQ-008 in_valid  input  1  request present on A/B/ALUK.
REQ-009 in_ready  output  1  block can accept a request this cycle.
REQ-010 Result  output  WIDTH  registered result.
REQ-011 NZP  output  3  registered condition code {N,Z,P} of Result.
REQ-012 C_V  output  2  registered {carry, overflow}.
REQ-013 ERR  output  1  registered illegal/disabled-operation flag.
REQ-014 out_valid  output  1  Result/NZP/C_V/ERR are valid.
REQ-015 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-016 Ops: 000 ADD A+B; 001 AND A&B; 010 NOT ~A; 011 PASS A; 100 SUB A-B; 101 SHL A<<B[4:0]; 110 SHR A>>B[4:0] (logical); 111 MUL, the low WIDTH bits of A*B (unsigned).
REQ-017 A request is accepted on a rising edge where in_valid and in_ready are both 1; A/B/ALUK are captured on that edge.
REQ-018 FSM states: IDLE, BUSY (MUL only), HOLD (result pending).
REQ-019 Single-cycle ops: IDLE --accept--> HOLD; out_valid rises the cycle after acceptance (latency 1).
REQ-020 MUL: IDLE --accept--> BUSY; iterative shift-add of 1 bit per cycle; BUSY lasts exactly WIDTH cycles, then HOLD (latency WIDTH+1).
REQ-021 HOLD --out_ready--> IDLE; outputs stay stable while out_valid=1 and out_ready=0.
REQ-022 in_ready = 1 in IDLE; in_ready = out_ready in HOLD (back-to-back: accept and retire on the same edge, go to HOLD or BUSY); in_ready = 0 in BUSY.
REQ-023 in_valid during BUSY is ignored; A/B changes during BUSY do not affect the result.
REQ-024 Carry: ADD carry-out; SUB borrow-free flag (carry = 1 when A >= B unsigned); SHL last bit shifted out; 0 for all other ops.
REQ-025 Overflow: signed two's-complement overflow for ADD/SUB; for MUL, 1 if the full 2*WIDTH product exceeds WIDTH bits; 0 otherwise.
REQ-026 Shift amount >= WIDTH gives Result 0 and carry 0.
REQ-027 NZP is one-hot from Result interpreted as signed: N if MSB=1, Z if Result=0, otherwise P.
REQ-028 ERR = 1 only for MUL with MUL_EN=0; in that case Result=0, NZP=010, and latency is 1.

Reset
REQ-029 While Reset_n=0: state IDLE, Result 0, NZP 010, C_V 00, ERR 0, out_valid 0.
REQ-030 in_ready=1 from the first cycle after Reset_n deasserts.
REQ-031 Reset during BUSY or HOLD abandons the operation; no out_valid is produced for it.

Structure
REQ-032 Package alu_pkg holds the ALUK opcode enum, the FSM state typedef, and the NZP bit-position constants.
REQ-033 The iterative multiplier is sub-module alu_mul_iter (ports: start, a, b, done, product of 2*WIDTH bits), instantiated only when MUL_EN=1.

Verification
REQ-034 WIDTH=16, ADD 0x7FFF+0x0001 -> one cycle later Result 0x8000, NZP 100, C_V 01.
REQ-035 SUB 0x0005-0x0005 -> Result 0x0000, NZP 010, C_V 10; NOT 0x00FF -> 0xFF00, NZP 100.
REQ-036 MUL 0x0123*0x0010 -> out_valid exactly 17 cycles after accept, Result 0x1230, overflow 0; in_ready 0 for the 16 BUSY cycles.
REQ-037 out_ready held 0 for 5 cycles after an ADD result -> Result stable, in_ready 0; out_ready=1 with a new in_valid -> retire and accept on the same edge, next result one cycle later.
REQ-038 Reset_n pulsed low mid-MUL (cycle 8) -> outputs reset immediately; no out_valid afterwards until a new request.
REQ-039 SHL 0x8001 by 1 -> Result 0x0002, carry 1; SHR by 20 -> Result 0, NZP 010.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   aluk_e   - 3-bit operation select encoding carried on the aluk port
//   state_e  - control FSM states (IDLE, BUSY while multiplying, HOLD with result pending)
//   NZP_*    - bit positions inside the {N,Z,P} condition code, plus its reset/zero value
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOT  = 3'b010,
        OP_PASS = 3'b011,
        OP_SUB  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } aluk_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_HOLD = 2'b10
    } state_e;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    localparam logic [2:0] NZP_ZERO = 3'b010;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : capture a/b and begin a new product (ignored bookkeeping-wise while running)
//   a, b         : WIDTH-bit unsigned operands, sampled only on the start edge
//   done         : high for one cycle once product holds the full result
//   product      : 2*WIDTH-bit accumulated product
// The start edge already folds in multiplier bit 0, so the remaining WIDTH-1 bits
// take WIDTH-1 further edges and done is visible WIDTH cycles after start.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               running;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand   <= {{WIDTH{1'b0}}, a} << 1;
            mplier  <= b >> 1;
            count   <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
            end
        end
    end

    assign done    = running && (count == '0);
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on both sides.
//   clk, reset_n          : clock and asynchronous active-low reset
//   a, b, aluk            : operands and operation select (see alu_pkg::aluk_e)
//   in_valid / in_ready   : request handshake; accepted when both are high on a rising edge
//   result, nzp, c_v, err : registered result, {N,Z,P}, {carry, overflow}, disabled-op flag
//   out_valid / out_ready : result handshake; outputs hold steady until out_ready
// Single-cycle ops land in HOLD one edge after acceptance; MUL spends WIDTH cycles
// in BUSY on the iterative multiplier first. With MUL_EN=0, MUL completes in one
// cycle with result 0 and err set.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluk,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp,
    output logic [1:0]       c_v,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        nzp_of = '0;
        if (v[WIDTH-1])    nzp_of[NZP_N] = 1'b1;
        else if (v == '0)  nzp_of[NZP_Z] = 1'b1;
        else               nzp_of[NZP_P] = 1'b1;
    endfunction

    // ---------------- single-cycle datapath ----------------
    logic [4:0]       shamt;
    logic             shift_big;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;

    assign shamt     = b[4:0];
    assign shift_big = (32'(shamt) >= 32'(WIDTH));
    assign add_ext   = {1'b0, a} + {1'b0, b};
    assign sub_res   = a - b;
    // The extra top bit catches the last bit shifted out for the SHL carry.
    assign shl_ext   = {1'b0, a} << shamt;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (aluk)
            OP_ADD: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_NOT:  alu_res = ~a;
            OP_PASS: alu_res = a;
            OP_SUB: begin
                alu_res   = sub_res;
                alu_carry = (a >= b);
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                if (!shift_big) begin
                    alu_res   = shl_ext[WIDTH-1:0];
                    alu_carry = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (!shift_big) alu_res = a >> shamt;
            end
            // Only reaches the output registers when the multiplier is absent.
            OP_MUL:  alu_err = (MUL_EN == 0);
            default: alu_res = '0;
        endcase
    end

    // ---------------- iterative multiplier ----------------
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset_n (reset_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // ---------------- control FSM ----------------
    state_e state_q;
    state_e state_d;
    logic   load_alu;
    logic   load_mul;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: begin
                if (mul_done) begin
                    state_d  = S_HOLD;
                    load_mul = 1'b1;
                end
            end
            S_HOLD: begin
                // Retiring and accepting may share an edge.
                in_ready = out_ready;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (in_valid && in_ready) begin
            if (aluk == OP_MUL && MUL_EN != 0) begin
                state_d   = S_BUSY;
                mul_start = 1'b1;
            end else begin
                state_d  = S_HOLD;
                load_alu = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            result  <= '0;
            nzp     <= NZP_ZERO;
            c_v     <= 2'b00;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                result <= alu_res;
                nzp    <= nzp_of(alu_res);
                c_v    <= {alu_carry, alu_ovf};
                err    <= alu_err;
            end else if (load_mul) begin
                result <= mul_product[WIDTH-1:0];
                nzp    <= nzp_of(mul_product[WIDTH-1:0]);
                c_v    <= {1'b0, |mul_product[2*WIDTH-1:WIDTH]};
                err    <= 1'b0;
            end
        end
    end

    assign out_valid = (state_q == S_HOLD);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=16).
// A behavioural model computes each accepted request's outputs with plain integer
// arithmetic and tracks when it is due; one negedge process compares the DUT against
// it every cycle. Directed cases pin the model with literal values, then randomized
// traffic with random back-pressure runs. A second instance with MUL_EN=0 covers ERR.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] a, b;
    logic [2:0]   aluk;
    logic         in_valid, in_ready;
    logic [W-1:0] result;
    logic [2:0]   nzp;
    logic [1:0]   c_v;
    logic         err, out_valid, out_ready;

    // MUL_EN=0 instance
    logic [W-1:0] n_a, n_b;
    logic [2:0]   n_aluk;
    logic         n_in_valid, n_in_ready;
    logic [W-1:0] n_result;
    logic [2:0]   n_nzp;
    logic [1:0]   n_c_v;
    logic         n_err, n_out_valid, n_out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .MUL_EN(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .aluk(aluk),
        .in_valid(in_valid), .in_ready(in_ready), .result(result), .nzp(nzp),
        .c_v(c_v), .err(err), .out_valid(out_valid), .out_ready(out_ready)
    );

    seq_alu #(.WIDTH(W), .MUL_EN(0)) u_dut_nomul (
        .clk(clk), .reset_n(reset_n), .a(n_a), .b(n_b), .aluk(n_aluk),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .result(n_result), .nzp(n_nzp),
        .c_v(n_c_v), .err(n_err), .out_valid(n_out_valid), .out_ready(n_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [W-1:0] r;
        logic [2:0]   nzp;
        logic [1:0]   cv;
        logic         err;
        int           lat;
    } exp_t;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint unsigned full;
        int sx = $signed(x);
        int sy = $signed(y);
        int s;
        int sh = int'(y[4:0]);
        e.r = '0; e.cv = 2'b00; e.err = 1'b0; e.lat = 1;
        case (op)
            3'd0: begin
                full = ux + uy; e.r = full[15:0];
                e.cv[1] = (full > 65535);
                s = sx + sy; e.cv[0] = (s > 32767) || (s < -32768);
            end
            3'd1: e.r = x & y;
            3'd2: e.r = ~x;
            3'd3: e.r = x;
            3'd4: begin
                full = ux - uy; e.r = full[15:0];
                e.cv[1] = (ux >= uy);
                s = sx - sy; e.cv[0] = (s > 32767) || (s < -32768);
            end
            3'd5: begin
                if (sh < W) begin
                    full = ux << sh; e.r = full[15:0]; e.cv[1] = full[16];
                end
            end
            3'd6: if (sh < W) e.r = 16'(ux >> sh);
            default: begin
                full = ux * uy; e.r = full[15:0];
                e.cv[0] = (full > 65535);
                e.lat = W + 1;
            end
        endcase
        if (e.r == 0)      e.nzp = 3'b010;
        else if (e.r[15])  e.nzp = 3'b100;
        else               e.nzp = 3'b001;
        return e;
    endfunction

    // pend: a request is outstanding; rem: edges left before its result is shown
    logic pend = 1'b0;
    int   rem  = 0;
    exp_t cur;

    always @(negedge clk) begin
        logic ready_e, retire, acc;
        if (!reset_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_result", result, 0);
            check("rst_nzp", nzp, 3'b010);
            check("rst_c_v", c_v, 0);
            check("rst_err", err, 0);
            pend = 1'b0;
            rem  = 0;
        end else begin
            ready_e = !pend || (rem == 0 && out_ready);
            check("in_ready", in_ready, ready_e);
            check("out_valid", out_valid, pend && rem == 0);
            if (pend && rem == 0) begin
                check("result", result, cur.r);
                check("nzp", nzp, cur.nzp);
                check("c_v", c_v, cur.cv);
                check("err", err, cur.err);
            end
            retire = pend && rem == 0 && out_ready;
            acc    = in_valid && ready_e;
            if (pend && rem > 0) rem--;
            if (retire) pend = 1'b0;
            if (acc) begin
                cur  = model(aluk, a, b);
                pend = 1'b1;
                rem  = cur.lat - 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ordy);
        in_valid  = v;
        aluk      = op;
        a         = x;
        b         = y;
        out_ready = ordy;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] r,
                              input logic [2:0] z, input logic [1:0] cv);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_result"}, result, r);
        check({name, "_nzp"}, nzp, z);
        check({name, "_c_v"}, c_v, cv);
    endtask

    task automatic one_shot(input string name, input logic [2:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] r,
                            input logic [2:0] z, input logic [1:0] cv);
        drive(1, op, x, y, 1);
        step();
        drive(0, OP_ADD, 0, 0, 1);
        expect_out(name, r, z, cv);
        step();
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int vcount;
        reset_n = 1'b0;
        drive(0, OP_ADD, 0, 0, 0);
        n_in_valid = 0; n_aluk = OP_ADD; n_a = 0; n_b = 0; n_out_ready = 1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        step();

        // directed cases with literal expectations
        one_shot("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 2'b01);
        one_shot("sub_eq",  OP_SUB, 16'h0005, 16'h0005, 16'h0000, 3'b010, 2'b10);
        one_shot("not",     OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 3'b100, 2'b00);
        one_shot("shl1",    OP_SHL, 16'h8001, 16'h0001, 16'h0002, 3'b001, 2'b10);
        one_shot("shr20",   OP_SHR, 16'hFFFF, 16'd20,   16'h0000, 3'b010, 2'b00);
        one_shot("and",     OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b001, 2'b00);

        // MUL latency and busy back-pressure; junk requests while busy are ignored
        drive(1, OP_MUL, 16'h0123, 16'h0010, 1);
        step();
        n = 1;
        while (!out_valid && n < 40) begin
            check("mul_busy_in_ready", in_ready, 0);
            drive(1, OP_ADD, 16'($urandom), 16'($urandom), 1);
            step();
            n++;
        end
        drive(0, OP_ADD, 0, 0, 1);
        check("mul_latency", n, W + 1);
        expect_out("mul", 16'h1230, 3'b001, 2'b00);
        step();

        // hold under back-pressure, then retire and accept on the same edge
        drive(1, OP_ADD, 16'h1234, 16'h4321, 0);
        step();
        drive(0, OP_ADD, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            expect_out("hold", 16'h5555, 3'b001, 2'b00);
            check("hold_in_ready", in_ready, 0);
            step();
        end
        drive(1, OP_PASS, 16'hABCD, 16'h0000, 1);
        step();
        drive(0, OP_ADD, 0, 0, 1);
        expect_out("b2b", 16'hABCD, 3'b100, 2'b00);
        step();

        // MUL_EN=0: MUL reports ERR with a zero result after one cycle
        n_in_valid = 1; n_aluk = OP_MUL; n_a = 16'h0003; n_b = 16'h0005;
        step();
        n_in_valid = 0;
        check("nomul_valid", n_out_valid, 1);
        check("nomul_err", n_err, 1);
        check("nomul_result", n_result, 0);
        check("nomul_nzp", n_nzp, 3'b010);
        step();
        n_in_valid = 1; n_aluk = OP_ADD; n_a = 16'h0002; n_b = 16'h0003;
        step();
        n_in_valid = 0;
        check("nomul_add_err", n_err, 0);
        check("nomul_add_result", n_result, 16'h0005);
        step();

        // reset in the middle of a MUL abandons it
        drive(1, OP_MUL, 16'hFFFF, 16'hFFFF, 1);
        step();
        drive(0, OP_ADD, 0, 0, 1);
        repeat (7) step();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_nzp", nzp, 3'b010);
        check("midrst_c_v", c_v, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) vcount++;
        end
        check("post_reset_no_valid", vcount, 0);

        // randomized traffic with random back-pressure
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(2) != 0), 3'($urandom_range(7)), rand_operand(),
                  rand_operand(), ($urandom_range(3) != 0));
            step();
        end
        drive(0, OP_ADD, 0, 0, 1);
        repeat (25) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
